muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits beside the execute stage, directly downstream of the register file read ports: operands arrive from the two register-file read data outputs. Results are held in HI/LO and are returned to the register file write port through the MFHI/MFLO path. Exposes a busy/done handshake so the pipeline control can stall MFHI/MFLO and new multiply/divide instructions while an operation is in flight.

## Interface
- `XLEN`, default 32: operand and HI/LO width. Only 32 is supported. The iteration counter is log2(XLEN)+1 bits.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `start` input, 1 bit: request an operation. Accepted only on an edge where `busy`=0.
- `op` input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a` input, 32 bits: rs operand (multiplicand/dividend).
- `b` input, 32 bits: rt operand (multiplier/divisor).
- `hi_wr` input, 1 bit: MTHI. HI <= `wdata`.
- `lo_wr` input, 1 bit: MTLO. LO <= `wdata`.
- `wdata` input, 32 bits: MTHI/MTLO data.
- `busy` output, 1 bit: operation in flight. Reset value 0.
- `done` output, 1 bit: one-cycle pulse when HI/LO take a new result. Reset value 0.
- `hi` output, 32 bits: HI register. Reset value 0.
- `lo` output, 32 bits: LO register. Reset value 0.

## Operation
- State machine:
  - IDLE: on `start`, latch `op`, |a|, |b| and the result signs (magnitudes are used for signed ops; unsigned ops use the operands as-is). Clear the counter and the 64-bit accumulator. Go to CALC.
  - CALC: one radix-2 step per cycle; 32 steps.
    - Multiply: shift-add.
    - Divide: restoring shift-subtract, one quotient bit per step.
    - After step 32, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, go to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = full 64-bit product (signed or unsigned).
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: no exception. LO = 0xFFFFFFFF, HI = `a` unchanged, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - Honoured only when `busy`=0 and `start`=0.
  - If they coincide with an accepted `start`, the start wins and the write is dropped.
  - While `busy`=1 they are ignored.
  - `hi_wr` and `lo_wr` may be asserted together.
- `start` while `busy`=1 is ignored. No queueing.
- `a`, `b` and `op` need only be valid on the accepting edge.

## Timing
- Edge E0 accepts `start`: `busy`=1 after E0.
- Edges E1..E32: iteration steps.
- Edge E33:
  - HI/LO updated.
  - `busy` falls to 0.
  - `done`=1 for exactly the cycle after E33.
- Latency: 33 cycles from acceptance to valid HI/LO.
- Back-to-back operations: a new `start` may be accepted at E34, in the same cycle `done` is high.
- `hi`/`lo` hold their previous values for the whole of the operation.
- Reset asserted at any time, including mid-operation:
  - Operation abandoned; state to IDLE.
  - `busy`=0, `done`=0, HI=LO=0, counter cleared.
  - Outputs change immediately, without waiting for `clk`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 64-bit combinational multiply.
  - Accepted at E0; HI/LO written at E1; `busy` is never asserted for a multiply; `done` is high in the cycle after E1.
  - Divide behaviour is unchanged.
- Not defined: multiplies use the iterative 33-cycle path described above.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. `done` in the cycle after E33 (after E1 with `MULDIV_FAST_MUL_EN`).
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- Control cases, in one sequence:
  - Second `start` at E5 is ignored; its operands never appear in HI/LO.
  - `hi_wr` with `wdata`=0x1234 at E10 is ignored.
  - Reset pulse at E20 -> `busy`=0 and HI=LO=0 immediately; no `done` follows.
  - After reset, `lo_wr` with `wdata`=0xCAFE -> LO=0xCAFE next cycle.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: pipeline-control <-> mul/div unit bundle.
// master drives requests and MTHI/MTLO, slave returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_wr;
  logic            lo_wr;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MIPS MULT/MULTU/DIV/DIVU with HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_FMUL
  } state_t;

  state_t            r_state;
  state_t            w_next;
  state_t            w_go;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_ma;
  logic [XLEN-1:0]   r_mb;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_div;
  logic              r_negq;
  logic              r_negr;
  logic              r_done;

  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic              w_mbit;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  logic              w_dbit;
  logic [XLEN:0]     w_rsh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rdif;
  logic [2*XLEN-1:0] w_div_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  assign w_accept = bus.start &&
                    (r_state == S_IDLE || r_state == S_FMUL);

  assign w_sa = ~bus.op[0] & bus.a[XLEN-1];
  assign w_sb = ~bus.op[0] & bus.b[XLEN-1];
  assign w_ma = w_sa ? -bus.a : bus.a;
  assign w_mb = w_sb ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fprod;
  assign w_fprod = {{XLEN{1'b0}}, r_ma} * {{XLEN{1'b0}}, r_mb};
  assign w_go    = bus.op[1] ? S_CALC : S_FMUL;
`else
  assign w_go    = S_CALC;
`endif

  // multiply: add multiplicand into upper half, shift right
  assign w_mbit    = r_mb[r_cnt[CW-2:0]];
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                     (w_mbit ? {1'b0, r_ma} : '0);
  assign w_mul_acc = {w_sum, r_acc[XLEN-1:1]};

  // divide: remainder in upper half, quotient shifts into lower half
  assign w_dbit    = r_ma[~r_cnt[CW-2:0]];
  assign w_rsh     = {r_acc[2*XLEN-1:XLEN], w_dbit};
  assign w_ge      = w_rsh >= {1'b0, r_mb};
  assign w_rdif    = w_rsh[XLEN-1:0] - r_mb;
  assign w_div_acc = {w_ge ? w_rdif : w_rsh[XLEN-1:0],
                      r_acc[XLEN-2:0], w_ge};

  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_q    = r_acc[XLEN-1:0];
  assign w_r    = r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (!r_div) begin
      {w_res_hi, w_res_lo} = w_prod;
    end else if (r_mb == '0) begin
      w_res_hi = r_negr ? -r_ma : r_ma;
      w_res_lo = '1;
    end else begin
      w_res_hi = r_negr ? -w_r : w_r;
      w_res_lo = r_negq ? -w_q : w_q;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (r_state == S_FMUL)
      {w_res_hi, w_res_lo} = r_negq ? -w_fprod : w_fprod;
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_FMUL: w_next = w_accept ? w_go : S_IDLE;
      S_CALC: if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_div  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_ma   <= w_ma;
      r_mb   <= w_mb;
      r_div  <= bus.op[1];
      r_negq <= w_sa ^ w_sb;
      r_negr <= w_sa;
    end else if (r_state == S_CALC) begin
      r_cnt  <= r_cnt + CW'(1);
      r_acc  <= r_div ? w_div_acc : w_mul_acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_FIX || r_state == S_FMUL) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end else if (r_state == S_IDLE && !bus.start) begin
        if (bus.hi_wr) r_hi <= bus.wdata;
        if (bus.lo_wr) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
